// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe : RV32I/RV32E instruction-decode stage with ID/EX register
//
// Decodes the instruction word presented by the IF/ID buffer, reads the
// register file (with write-through bypass from writeback), detects load-use
// hazards against the instruction held in ID/EX and owns the ID/EX pipeline
// register with a valid/ready handshake, stall and flush.
//
// Parameters
//   XLEN  datapath / register width (>= 32)
//   NREG  architectural register count, 16 (RV32E) or 32
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   id_valid_i/id_pc_i/id_ir_i  instruction offered by IF/ID
//   id_ready_o               instruction is consumed (accepted or dropped)
//   flush_i                  kill ID and ID/EX contents (redirect)
//   wb_load_i/wb_rd_i/wb_data_i register-file write port from writeback
//   ex_ready_i               execute accepts the ID/EX contents
//   ex_valid_o, ex_*_o       registered ID/EX payload
//
// Optional feature (macro ID_STALL_CNT_EN)
//   stall_cnt_o   cycles with id_valid_i && !id_ready_o
//   bubble_cnt_o  load-use bubbles inserted
// ---------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [31:0]     id_ir_i,
    output logic            id_ready_o,
    input  logic            flush_i,
    input  logic            wb_load_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            ex_ready_i,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_rs1_o,
    output logic [XLEN-1:0] ex_rs2_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [4:0]      ex_rs1_idx_o,
    output logic [4:0]      ex_rs2_idx_o,
    output logic [4:0]      ex_rd_o,
    output logic [6:0]      ex_opcode_o,
    output logic [2:0]      ex_funct3_o,
    output logic [6:0]      ex_funct7_o,
    output logic            ex_is_load_o
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     bubble_cnt_o
`endif
);

    localparam int AW = $clog2(NREG);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_idx;
        logic [4:0]      rs2_idx;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            is_load;
    } idex_t;

    // ---------------------------------------------------------------------
    // Field decode
    // ---------------------------------------------------------------------
    logic [6:0] opcode;
    logic [4:0] rd_idx;
    logic [2:0] funct3;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic [6:0] funct7;

    assign opcode  = id_ir_i[6:0];
    assign rd_idx  = id_ir_i[11:7];
    assign funct3  = id_ir_i[14:12];
    assign rs1_idx = id_ir_i[19:15];
    assign rs2_idx = id_ir_i[24:20];
    assign funct7  = id_ir_i[31:25];

    logic [31:0] imm32;

    // NOTE: every always_comb output gets a default before the case/if tree,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        imm32 = '0;
        unique case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm32 = {{20{id_ir_i[31]}}, id_ir_i[31:20]};
            OPC_STORE:
                imm32 = {{20{id_ir_i[31]}}, id_ir_i[31:25], id_ir_i[11:7]};
            OPC_BRANCH:
                imm32 = {{19{id_ir_i[31]}}, id_ir_i[31], id_ir_i[7],
                         id_ir_i[30:25], id_ir_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {id_ir_i[31:12], 12'b0};
            OPC_JAL:
                imm32 = {{11{id_ir_i[31]}}, id_ir_i[31], id_ir_i[19:12],
                         id_ir_i[20], id_ir_i[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [NREG];
    logic            rf_we;

    // Indices above the implemented range (RV32E) behave as hard-wired zero.
    function automatic logic in_range(input logic [4:0] idx);
        return int'(idx) < NREG;
    endfunction

    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        logic [XLEN-1:0] val;
        val = '0;
        if (idx != 5'd0 && in_range(idx)) begin
            // Write-through: a same-cycle writeback is visible to the reader.
            if (wb_load_i && wb_rd_i == idx) val = wb_data_i;
            else                             val = rf_q[idx[AW-1:0]];
        end
        return val;
    endfunction

    assign rf_we = wb_load_i && (wb_rd_i != 5'd0) && in_range(wb_rd_i);

    // NOTE: the register file is cleared by reset along with every other
    // register, so operand values read after reset are deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[wb_rd_i[AW-1:0]] <= wb_data_i;
        end
    end

    // ---------------------------------------------------------------------
    // Hazard detection and ID/EX control
    // ---------------------------------------------------------------------
    idex_t ex_q, ex_d, id_payload;
    logic  ex_valid_q, ex_valid_d;
    logic  use_rs1, use_rs2;
    logic  ex_stall;
    logic  load_use;
    logic  bubble;
    logic  id_ready;

    assign use_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    assign use_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    assign ex_stall = ex_valid_q && !ex_ready_i;
    assign load_use = id_valid_i && ex_valid_q && ex_q.is_load && (ex_q.rd != 5'd0) &&
                      ((use_rs1 && rs1_idx == ex_q.rd) || (use_rs2 && rs2_idx == ex_q.rd));

    always_comb begin
        id_payload.pc      = id_pc_i;
        id_payload.rs1     = rf_read(rs1_idx);
        id_payload.rs2     = rf_read(rs2_idx);
        id_payload.imm     = XLEN'($signed(imm32));
        id_payload.rs1_idx = rs1_idx;
        id_payload.rs2_idx = rs2_idx;
        id_payload.rd      = rd_idx;
        id_payload.opcode  = opcode;
        id_payload.funct3  = funct3;
        id_payload.funct7  = funct7;
        id_payload.is_load = (opcode == OPC_LOAD);
    end

    // Priority: flush, back-pressure, load-use bubble, normal advance.
    // In reset ex_valid_q is 0, so this resolves to id_ready = 1.
    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        id_ready   = 1'b1;
        bubble     = 1'b0;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (ex_stall) begin
            id_ready = 1'b0;
        end else if (load_use) begin
            ex_valid_d = 1'b0;
            id_ready   = 1'b0;
            bubble     = 1'b1;
        end else begin
            ex_valid_d = id_valid_i;
            if (id_valid_i) ex_d = id_payload;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign id_ready_o   = id_ready;
    assign ex_valid_o   = ex_valid_q;
    assign ex_pc_o      = ex_q.pc;
    assign ex_rs1_o     = ex_q.rs1;
    assign ex_rs2_o     = ex_q.rs2;
    assign ex_imm_o     = ex_q.imm;
    assign ex_rs1_idx_o = ex_q.rs1_idx;
    assign ex_rs2_idx_o = ex_q.rs2_idx;
    assign ex_rd_o      = ex_q.rd;
    assign ex_opcode_o  = ex_q.opcode;
    assign ex_funct3_o  = ex_q.funct3;
    assign ex_funct7_o  = ex_q.funct7;
    assign ex_is_load_o = ex_q.is_load;

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (id_valid_i && !id_ready) stall_cnt_q  <= stall_cnt_q + 32'd1;
            if (bubble)                  bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe : scoreboard bench for id_stage_pipe (RV32E build, NREG=16)
//
// A behavioural model (architectural register array, immediate arithmetic,
// one-deep queue of expected ID/EX contents) runs alongside the DUT. A
// negedge monitor compares handshake outputs every cycle and the ID/EX
// payload against the queue head. Directed sequences cover the named corner
// cases, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;

    localparam int XLEN = 32;
    localparam int NREG = 16;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rs1_idx;
        logic [4:0]  rs2_idx;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        is_load;
    } pay_t;

    logic        clk;
    logic        rst;
    logic        id_valid_i;
    logic [31:0] id_pc_i;
    logic [31:0] id_ir_i;
    logic        id_ready_o;
    logic        flush_i;
    logic        wb_load_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        ex_ready_i;
    logic        ex_valid_o;
    logic [31:0] ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o;
    logic [4:0]  ex_rs1_idx_o, ex_rs2_idx_o, ex_rd_o;
    logic [6:0]  ex_opcode_o;
    logic [2:0]  ex_funct3_o;
    logic [6:0]  ex_funct7_o;
    logic        ex_is_load_o;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_o, bubble_cnt_o;
`endif

    id_stage_pipe #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid_i   (id_valid_i),
        .id_pc_i      (id_pc_i),
        .id_ir_i      (id_ir_i),
        .id_ready_o   (id_ready_o),
        .flush_i      (flush_i),
        .wb_load_i    (wb_load_i),
        .wb_rd_i      (wb_rd_i),
        .wb_data_i    (wb_data_i),
        .ex_ready_i   (ex_ready_i),
        .ex_valid_o   (ex_valid_o),
        .ex_pc_o      (ex_pc_o),
        .ex_rs1_o     (ex_rs1_o),
        .ex_rs2_o     (ex_rs2_o),
        .ex_imm_o     (ex_imm_o),
        .ex_rs1_idx_o (ex_rs1_idx_o),
        .ex_rs2_idx_o (ex_rs2_idx_o),
        .ex_rd_o      (ex_rd_o),
        .ex_opcode_o  (ex_opcode_o),
        .ex_funct3_o  (ex_funct3_o),
        .ex_funct7_o  (ex_funct7_o),
        .ex_is_load_o (ex_is_load_o)
`ifdef ID_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkp(input string name, input pay_t act, input pay_t exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic pay_t dut_pay();
        pay_t p;
        p = {ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o, ex_rs1_idx_o, ex_rs2_idx_o,
             ex_rd_o, ex_opcode_o, ex_funct3_o, ex_funct7_o, ex_is_load_o};
        return p;
    endfunction

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    logic [31:0] rf [32];
    logic        mv;          // model: ID/EX holds a valid instruction
    logic        m_ld;
    logic [4:0]  m_rd;
    logic        m_acc;       // model: ID instruction consumed at last edge
    logic [31:0] m_stall, m_bub;
    pay_t        exp_q [$];

    function automatic logic [31:0] model_imm(input logic [31:0] ir);
        int s;
        s = ir;
        case (ir[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: return 32'(s >>> 20);
            OPC_STORE:  return 32'((s >>> 25) <<< 5) | 32'(ir[11:7]);
            OPC_BRANCH: return 32'((s >>> 31) <<< 12) | (32'(ir[7]) << 11) |
                               (32'(ir[30:25]) << 5) | (32'(ir[11:8]) << 1);
            OPC_LUI, OPC_AUIPC: return ir & 32'hFFFF_F000;
            OPC_JAL:    return 32'((s >>> 31) <<< 20) | (32'(ir[19:12]) << 12) |
                               (32'(ir[20]) << 11) | (32'(ir[30:21]) << 1);
            default:    return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0 || idx >= NREG) return 32'd0;
        if (wb_load_i && wb_rd_i == idx) return wb_data_i;
        return rf[idx];
    endfunction

    function automatic logic model_hazard();
        logic [6:0] op;
        logic u1, u2;
        op = id_ir_i[6:0];
        u1 = !(op inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        u2 = op inside {OPC_OP, OPC_STORE, OPC_BRANCH};
        return id_valid_i && mv && m_ld && m_rd != 5'd0 &&
               ((u1 && id_ir_i[19:15] == m_rd) || (u2 && id_ir_i[24:20] == m_rd));
    endfunction

    function automatic logic model_ready();
        if (flush_i)             return 1'b1;
        if (mv && !ex_ready_i)   return 1'b0;
        return !model_hazard();
    endfunction

    function automatic pay_t model_payload();
        pay_t p;
        p.pc      = id_pc_i;
        p.rs1     = model_read(id_ir_i[19:15]);
        p.rs2     = model_read(id_ir_i[24:20]);
        p.imm     = model_imm(id_ir_i);
        p.rs1_idx = id_ir_i[19:15];
        p.rs2_idx = id_ir_i[24:20];
        p.rd      = id_ir_i[11:7];
        p.opcode  = id_ir_i[6:0];
        p.funct3  = id_ir_i[14:12];
        p.funct7  = id_ir_i[31:25];
        p.is_load = (id_ir_i[6:0] == OPC_LOAD);
        return p;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mv      <= 1'b0;
            m_ld    <= 1'b0;
            m_rd    <= 5'd0;
            m_acc   <= 1'b0;
            m_stall <= 32'd0;
            m_bub   <= 32'd0;
            exp_q.delete();
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else begin
            m_acc <= id_valid_i && model_ready();
            if (id_valid_i && !model_ready()) m_stall <= m_stall + 32'd1;
            if (flush_i) begin
                if (mv) void'(exp_q.pop_front());
                mv <= 1'b0;
            end else if (mv && !ex_ready_i) begin
                mv <= 1'b1;
            end else if (model_hazard()) begin
                mv    <= 1'b0;
                m_bub <= m_bub + 32'd1;
            end else begin
                mv <= id_valid_i;
                if (id_valid_i) begin
                    exp_q.push_back(model_payload());
                    m_ld <= (id_ir_i[6:0] == OPC_LOAD);
                    m_rd <= id_ir_i[11:7];
                end
            end
            if (wb_load_i && wb_rd_i != 5'd0 && wb_rd_i < NREG) rf[wb_rd_i] <= wb_data_i;
        end
    end

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            check("ex_valid", 32'(ex_valid_o), 32'(mv));
            check("id_ready", 32'(id_ready_o), 32'(model_ready()));
            if (mv) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL scoreboard_empty: got no expected entry, required one (t=%0t)", $time);
                end else begin
                    checkp("ex_payload", dut_pay(), exp_q[0]);
                    if (ex_ready_i && !flush_i) void'(exp_q.pop_front());
                end
            end
`ifdef ID_STALL_CNT_EN
            check("stall_cnt", stall_cnt_o, m_stall);
            check("bubble_cnt", bubble_cnt_o, m_bub);
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
    endfunction

    logic [4:0] reg_pool [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd15, 5'd16, 5'd20, 5'd31};

    function automatic logic [4:0] pick_reg();
        return reg_pool[$urandom_range(0, 9)];
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [6:0]  ops [10] = '{OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
                                  OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, 7'b1111111};
        logic [31:0] ir;
        ir        = $urandom;
        ir[6:0]   = ops[$urandom_range(0, 9)];
        if (ir[6:0] == 7'b1111111) ir[6:0] = 7'($urandom);
        ir[11:7]  = pick_reg();
        ir[19:15] = pick_reg();
        ir[24:20] = pick_reg();
        return ir;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction and wait until it is consumed.
    task automatic send(input logic [31:0] pc, input logic [31:0] ir);
        id_valid_i = 1'b1;
        id_pc_i    = pc;
        id_ir_i    = ir;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (m_acc) return;
        end
        n_checks++;
        n_err++;
        $display("FAIL send_timeout: got no acceptance in 50 cycles, required acceptance (pc=0x%08h)", pc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test by t=%0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    logic [31:0] bub_base;

    initial begin
        rst = 1'b1; id_valid_i = 0; id_pc_i = 0; id_ir_i = 0; flush_i = 0;
        wb_load_i = 0; wb_rd_i = 0; wb_data_i = 0; ex_ready_i = 1;
        tick(); tick();
        check("rst_ex_valid", 32'(ex_valid_o), 0);
        check("rst_id_ready", 32'(id_ready_o), 1);
        checkp("rst_payload", dut_pay(), '0);
        rst = 1'b0;
        tick();

        // Write then read through ADD x1,x5,x5
        wb_load_i = 1; wb_rd_i = 5; wb_data_i = 32'hDEADBEEF;
        tick();
        wb_load_i = 0;
        send(32'h100, r_type(7'd0, 5'd5, 5'd5, 3'd0, 5'd1, OPC_OP));
        check("add_latency_valid", 32'(ex_valid_o), 1);
        check("add_rs1", ex_rs1_o, 32'hDEADBEEF);
        check("add_rs2", ex_rs2_o, 32'hDEADBEEF);
        id_valid_i = 0;

        // Write-through bypass on x7
        wb_load_i = 1; wb_rd_i = 7; wb_data_i = 32'h1234;
        send(32'h104, i_type(12'd0, 5'd7, 3'd0, 5'd2, OPC_OP_IMM));
        check("bypass_rs1", ex_rs1_o, 32'h1234);
        id_valid_i = 0;
        // x0 ignores writes
        wb_load_i = 1; wb_rd_i = 0; wb_data_i = 32'd5;
        tick();
        wb_load_i = 0;
        send(32'h108, i_type(12'd0, 5'd0, 3'd0, 5'd3, OPC_OP_IMM));
        check("x0_read", ex_rs1_o, 0);
        id_valid_i = 0;
        // x20 is outside RV32E; must not alias x4
        wb_load_i = 1; wb_rd_i = 4; wb_data_i = 32'h55;
        tick();
        wb_rd_i = 20; wb_data_i = 32'hAAAA;
        tick();
        wb_load_i = 0;
        send(32'h10C, r_type(7'd0, 5'd4, 5'd20, 3'd0, 5'd1, OPC_OP));
        check("x20_read", ex_rs1_o, 0);
        check("x4_read", ex_rs2_o, 32'h55);
        id_valid_i = 0;
        tick();

        // Three load-use pairs, each costing exactly one bubble
`ifdef ID_STALL_CNT_EN
        bub_base = bubble_cnt_o;
`else
        bub_base = 0;
`endif
        for (int k = 0; k < 3; k++) begin
            logic [4:0] r;
            r = (k == 0) ? 5'd3 : 5'(7 + k);
            send(32'h200 + 32'(k * 16), i_type(12'd0, 5'd2, 3'b010, r, OPC_LOAD));
            id_pc_i = 32'h204 + 32'(k * 16);
            id_ir_i = r_type(7'd0, 5'd1, r, 3'd0, 5'd4, OPC_OP);
            #1;
            check("lu_ready_low", 32'(id_ready_o), 0);
            tick();
            check("lu_bubble", 32'(ex_valid_o), 0);
            check("lu_ready_high", 32'(id_ready_o), 1);
            tick();
            check("lu_issue_valid", 32'(ex_valid_o), 1);
            check("lu_issue_rd", 32'(ex_rd_o), 4);
            id_valid_i = 0;
        end
`ifdef ID_STALL_CNT_EN
        check("bubble_cnt_3", bubble_cnt_o - bub_base, 3);
`endif

        // LW x3 then LUI x3 (rs1 field happens to be 3): no bubble
        send(32'h300, i_type(12'd0, 5'd2, 3'b010, 5'd3, OPC_LOAD));
        id_pc_i = 32'h304;
        id_ir_i = {20'h00018, 5'd3, OPC_LUI};
        #1;
        check("lui_no_bubble", 32'(id_ready_o), 1);
        tick();
        check("lui_issue_valid", 32'(ex_valid_o), 1);
        check("lui_issue_op", 32'(ex_opcode_o), 32'(OPC_LUI));
        id_valid_i = 0;

        // Back-pressure for three cycles, then flush during the stall
        send(32'h400, r_type(7'd0, 5'd1, 5'd2, 3'd0, 5'd5, OPC_OP));
        ex_ready_i = 0;
        id_valid_i = 1; id_pc_i = 32'h404; id_ir_i = i_type(12'd7, 5'd1, 3'd0, 5'd6, OPC_OP_IMM);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_ready", 32'(id_ready_o), 0);
            check("stall_pc_hold", ex_pc_o, 32'h400);
            tick();
        end
        flush_i = 1;
        #1;
        check("flush_ready", 32'(id_ready_o), 1);
        tick();
        check("flush_valid", 32'(ex_valid_o), 0);
        flush_i = 0; id_valid_i = 0; ex_ready_i = 1;
        tick();

        // Immediate boundaries
        send(32'h500, b_type(13'h1FF8, 5'd2, 5'd1, 3'b000));
        check("beq_imm", ex_imm_o, 32'hFFFFFFF8);
        send(32'h504, j_type(21'h000800, 5'd1));
        check("jal_imm", ex_imm_o, 32'h00000800);
        id_valid_i = 0;
        tick();

        // Asynchronous reset in the middle of a stall
        send(32'h600, i_type(12'd0, 5'd2, 3'b010, 5'd3, OPC_LOAD));
        ex_ready_i = 0;
        id_pc_i = 32'h604; id_ir_i = r_type(7'd0, 5'd1, 5'd3, 3'd0, 5'd4, OPC_OP);
        tick();
        #2;
        rst = 1; id_valid_i = 0;
        #1;
        check("arst_ex_valid", 32'(ex_valid_o), 0);
        checkp("arst_payload", dut_pay(), '0);
        check("arst_id_ready", 32'(id_ready_o), 1);
`ifdef ID_STALL_CNT_EN
        check("arst_stall_cnt", stall_cnt_o, 0);
        check("arst_bubble_cnt", bubble_cnt_o, 0);
`endif
        tick();
        rst = 0; ex_ready_i = 1;
        tick();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if (!id_valid_i || m_acc) begin
                id_valid_i = ($urandom_range(0, 9) < 8);
                id_ir_i    = rand_ir();
                id_pc_i    = $urandom & 32'hFFFF_FFFC;
            end
            flush_i    = ($urandom_range(0, 31) == 0);
            ex_ready_i = ($urandom_range(0, 3) != 0);
            wb_load_i  = $urandom_range(0, 1) == 1;
            wb_rd_i    = pick_reg();
            wb_data_i  = $urandom;
            tick();
        end
        id_valid_i = 0; flush_i = 0; ex_ready_i = 1; wb_load_i = 0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
